// File: rtl/ifu_pkg.sv
// rtl/ifu_pkg.sv - shared opcode/format constants, decoded-instruction struct and FSM states
// for the instruction fetch unit (optional bounds check: IFU_BOUNDS_CHECK_EN in instr_fetch_unit).
package ifu_pkg;

    localparam int LOC_W = 16;

    localparam logic [3:0] OP_JMP  = 4'b0010;
    localparam logic [3:0] OP_BR   = 4'b0100;
    localparam logic [3:0] OP_MVB  = 4'b0101;
    localparam logic [3:0] OP_MVF  = 4'b0110;
    localparam logic [3:0] OP_IMM0 = 4'b1001;
    localparam logic [3:0] OP_IMM1 = 4'b1101;
    localparam logic [3:0] OP_HALT = 4'b1110;
    localparam logic [3:0] OP_EXT  = 4'b1111;

    typedef enum logic [1:0] {
        FMT_M = 2'd0,
        FMT_C = 2'd1,
        FMT_I = 2'd2,
        FMT_X = 2'd3
    } fmt_t;

    typedef struct packed {
        fmt_t             format;
        logic [3:0]       opcode;
        logic [2:0]       reg1_i;
        logic [2:0]       reg2_i;
        logic [2:0]       reg_o;
        logic [2:0]       imm;
        logic             imm_flag;
        logic [LOC_W-1:0] jmp_loc;
    } dec_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } fsm_t;

endpackage

// File: rtl/ifu_decode.sv
// rtl/ifu_decode.sv - purely combinational decode of one 8-bit instruction word into dec_t,
// resolving label-based jump targets from the flattened label table.
module ifu_decode
    import ifu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int NUM_LBL = 16
) (
    input  logic [7:0]              instr,
    input  logic [NUM_LBL*ADDR_W-1:0] lbl_flat,
    output dec_t                    dec
);

    logic       use_lbl;
    logic [3:0] lbl_idx;

    always_comb begin
        dec        = '0;
        use_lbl    = 1'b0;
        lbl_idx    = '0;
        dec.opcode = instr[7:4];
        case (instr[7:4])
            OP_JMP, OP_BR: begin
                dec.format = FMT_C;
                dec.reg_o  = instr[0] ? 3'd3 : 3'd2;
                use_lbl    = 1'b1;
                lbl_idx    = instr[3:0];
            end
            OP_IMM0, OP_IMM1: begin
                dec.format   = FMT_I;
                dec.reg1_i   = instr[3:1];
                dec.reg2_i   = instr[3:1] + 3'd1;
                dec.reg_o    = instr[3:1];
                dec.imm      = instr[3:1];
                dec.imm_flag = instr[0];
            end
            OP_HALT, OP_EXT: begin
                dec.format = FMT_X;
            end
            OP_MVB: begin
                dec.format = FMT_M;
                dec.reg1_i = {1'b1, instr[1:0]};
                dec.reg_o  = {1'b0, instr[3:2]};
                use_lbl    = 1'b1;
                lbl_idx    = {2'b11, instr[1:0]};
            end
            default: begin
                dec.format = FMT_M;
                dec.reg1_i = {1'b0, instr[3:2]};
                dec.reg2_i = {1'b0, instr[3:2]} + 3'd1;
                dec.reg_o  = {1'b1, instr[1:0]};
                use_lbl    = 1'b1;
                lbl_idx    = {2'b11, instr[1:0]};
            end
        endcase
        if (use_lbl) begin
            dec.jmp_loc = LOC_W'(lbl_flat[lbl_idx*ADDR_W +: ADDR_W]);
        end
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - instruction fetch unit: imem + label table, IDLE/RUN/HALTED fetch FSM,
// one registered decoded output with valid/ready; IFU_BOUNDS_CHECK_EN enables out-of-range fetch error.
module instr_fetch_unit
    import ifu_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DEPTH   = 256,
    parameter int NUM_LBL = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_pc,
    input  logic                     redirect_valid,
    input  logic [ADDR_W-1:0]        redirect_pc,
    input  logic                     imem_we,
    input  logic [$clog2(DEPTH)-1:0] imem_waddr,
    input  logic [7:0]               imem_wdata,
    input  logic                     lbl_we,
    input  logic [3:0]               lbl_waddr,
    input  logic [ADDR_W-1:0]        lbl_wdata,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [ADDR_W-1:0]        out_pc,
    output dec_t                     out_dec,
    output logic                     halted,
    output logic                     err
);

    localparam int IW = $clog2(DEPTH);

    logic [7:0]                imem [DEPTH];
    logic [ADDR_W-1:0]         lbl  [NUM_LBL];
    logic [NUM_LBL*ADDR_W-1:0] lbl_flat;
    logic [ADDR_W-1:0]         pc;
    logic [7:0]                instr;
    dec_t                      fetch_dec;
    fsm_t                      state;

    // Instruction memory is deliberately not reset; reads are asynchronous so a
    // same-edge write is only visible to the following fetch.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LBL; i++) begin
                lbl[i] <= '0;
            end
        end else if (lbl_we) begin
            lbl[lbl_waddr] <= lbl_wdata;
        end
    end

    for (genvar g = 0; g < NUM_LBL; g++) begin : g_lbl_flat
        assign lbl_flat[g*ADDR_W +: ADDR_W] = lbl[g];
    end

    assign instr = imem[pc[IW-1:0]];

    ifu_decode #(
        .ADDR_W  (ADDR_W),
        .NUM_LBL (NUM_LBL)
    ) u_decode (
        .instr    (instr),
        .lbl_flat (lbl_flat),
        .dec      (fetch_dec)
    );

`ifdef IFU_BOUNDS_CHECK_EN
    logic err_q;
    logic oob;
    assign oob = (32'(pc) >= DEPTH);
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= '0;
            out_valid <= 1'b0;
            out_pc    <= '0;
            out_dec   <= '0;
            halted    <= 1'b0;
`ifdef IFU_BOUNDS_CHECK_EN
            err_q     <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state <= ST_RUN;
                        pc    <= start_pc;
                    end
                end
                ST_RUN: begin
                    if (redirect_valid) begin
                        pc        <= redirect_pc;
                        out_valid <= 1'b0;
                    end else if (!out_valid || out_ready) begin
`ifdef IFU_BOUNDS_CHECK_EN
                        if (oob) begin
                            err_q     <= 1'b1;
                            out_valid <= 1'b0;
                            state     <= ST_HALTED;
                            halted    <= 1'b1;
                        end else begin
`else
                        begin
`endif
                            out_valid <= 1'b1;
                            out_pc    <= pc;
                            out_dec   <= fetch_dec;
                            pc        <= pc + 1'b1;
                            // The HALT word is still presented; only further fetches stop.
                            if (fetch_dec.opcode == OP_HALT) begin
                                state  <= ST_HALTED;
                                halted <= 1'b1;
                            end
                        end
                    end
                end
                ST_HALTED: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                    end
                    if (start) begin
                        state  <= ST_RUN;
                        pc     <= start_pc;
                        halted <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - scoreboard bench for instr_fetch_unit with a program-walk reference model.
module tb_instr_fetch_unit;
    import ifu_pkg::*;

    localparam int ADDR_W = 16;
    localparam int DEPTH  = 256;

    typedef struct packed {
        logic [15:0] pc;
        dec_t        dec;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] start_pc = '0;
    logic        redirect_valid = 1'b0;
    logic [15:0] redirect_pc = '0;
    logic        imem_we = 1'b0;
    logic [7:0]  imem_waddr = '0;
    logic [7:0]  imem_wdata = '0;
    logic        lbl_we = 1'b0;
    logic [3:0]  lbl_waddr = '0;
    logic [15:0] lbl_wdata = '0;
    logic        out_ready = 1'b0;
    logic        out_valid;
    logic [15:0] out_pc;
    dec_t        out_dec;
    logic        halted;
    logic        err;

    logic [7:0]  mem_m [DEPTH];
    logic [15:0] lbl_m [16];
    exp_t        sb_q [$];
    int          n_vec = 0;
    int          n_err = 0;

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .NUM_LBL(16)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .start_pc       (start_pc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_we        (imem_we),
        .imem_waddr     (imem_waddr),
        .imem_wdata     (imem_wdata),
        .lbl_we         (lbl_we),
        .lbl_waddr      (lbl_waddr),
        .lbl_wdata      (lbl_wdata),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_dec        (out_dec),
        .halted         (halted),
        .err            (err)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic dec_t ref_dec(input logic [7:0] w);
        dec_t d;
        int   op, lo, r;
        op = int'(w[7:4]);
        lo = int'(w[3:0]);
        d = '0;
        d.opcode = w[7:4];
        if (op == 2 || op == 4) begin
            d.format  = FMT_C;
            d.reg_o   = (lo % 2 == 1) ? 3'd3 : 3'd2;
            d.jmp_loc = lbl_m[lo];
        end else if (op == 9 || op == 13) begin
            r = lo / 2;
            d.format   = FMT_I;
            d.reg1_i   = 3'(r);
            d.reg2_i   = 3'((r + 1) % 8);
            d.reg_o    = 3'(r);
            d.imm      = 3'(r);
            d.imm_flag = 1'(lo % 2);
        end else if (op >= 14) begin
            d.format = FMT_X;
        end else begin
            d.format = FMT_M;
            if (op == 5) begin
                d.reg1_i = 3'(4 + lo % 4);
                d.reg_o  = 3'(lo / 4);
            end else begin
                d.reg1_i = 3'(lo / 4);
                d.reg2_i = 3'(lo / 4 + 1);
                d.reg_o  = 3'(4 + lo % 4);
            end
            d.jmp_loc = lbl_m[12 + lo % 4];
        end
        return d;
    endfunction

    // Expected program order: consecutive words from s up to and including the first HALT.
    task automatic push_walk(input int s);
        exp_t e;
        int   p;
        p = s;
        for (int n = 0; n < DEPTH; n++) begin
            e.pc  = 16'(p);
            e.dec = ref_dec(mem_m[p % DEPTH]);
            sb_q.push_back(e);
            if (mem_m[p % DEPTH][7:4] == 4'hE) break;
            p = (p + 1) % 65536;
        end
    endtask

    function automatic logic [7:0] rnd_byte();
        logic [7:0] w;
        do w = 8'($urandom); while (w[7:4] == 4'hE);
        return w;
    endfunction

    task automatic wr_mem(input int a, input logic [7:0] d);
        imem_we = 1'b1;
        imem_waddr = 8'(a);
        imem_wdata = d;
        mem_m[a] = d;
        @(posedge clk); #1;
        imem_we = 1'b0;
    endtask

    task automatic wr_lbl(input int a, input logic [15:0] d);
        lbl_we = 1'b1;
        lbl_waddr = 4'(a);
        lbl_wdata = d;
        lbl_m[a] = d;
        @(posedge clk); #1;
        lbl_we = 1'b0;
    endtask

    // mode 0: random out_ready; 1: always ready, latency checked; 2: 5-cycle stall then redirect.
    task automatic run_prog(input int s, input int mode, input int t, input bit redir);
        int n_words, c, stall_left;
        bit redirected, flush_pending;
        push_walk(s);
        n_words = sb_q.size();
        start_pc = 16'(s);
        start = 1'b1;
        out_ready = 1'b1;
        stall_left = (mode == 2) ? 5 : 0;
        redirected = 1'b0;
        flush_pending = 1'b0;
        for (c = 0; c < 1000; c++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (flush_pending) begin
                check("redirect_bubble", 64'(out_valid), 64'(0));
                sb_q.delete();
                push_walk(t);
                flush_pending = 1'b0;
                redirect_valid = 1'b0;
            end
            if (halted && !out_valid) break;
            if (stall_left > 0 && out_valid) begin
                out_ready = 1'b0;
                stall_left--;
            end else if (redir && !redirected && !halted &&
                         (mode == 2 ? (out_valid && stall_left == 0) : ($urandom_range(5) == 0))) begin
                redirect_valid = 1'b1;
                redirect_pc = 16'(t);
                redirected = 1'b1;
                flush_pending = 1'b1;
                out_ready = (mode == 2) ? 1'b0 : 1'($urandom);
            end else begin
                out_ready = (mode != 0) ? 1'b1 : ($urandom_range(3) != 0);
            end
        end
        check("halt_reached", 64'(halted), 64'(1));
        check("sb_drained", 64'(sb_q.size()), 64'(0));
        if (mode == 1) check("consecutive_words", 64'(c), 64'(n_words + 1));
        sb_q.delete();
        out_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb_q.size() == 0) begin
                check("spurious_valid", 64'(out_valid), 64'(0));
            end else begin
                check("word", 64'({out_pc, out_dec}), 64'(sb_q[0]));
                if (out_ready) void'(sb_q.pop_front());
            end
        end
    end

    initial begin
        int s, t, len, l2;
        #12;
        check("reset_state", 64'({out_valid, out_pc, out_dec, halted, err}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) wr_mem(a, rnd_byte());
        for (int i = 0; i < 16; i++) wr_lbl(i, (i == 3) ? 16'h0040 : 16'($urandom));

        wr_mem(0, 8'h40); wr_mem(1, 8'h69); wr_mem(2, 8'hE0);
        run_prog(0, 1, 0, 1'b0);

        wr_mem(10, 8'h23); wr_mem(11, 8'h54); wr_mem(12, 8'hF3); wr_mem(13, 8'hE0);
        wr_mem(50, 8'h69); wr_mem(51, 8'hE0);
        run_prog(10, 2, 50, 1'b1);

        for (int k = 0; k < 20; k++) begin
            s   = $urandom_range(60, DEPTH - 40);
            len = $urandom_range(2, 20);
            t   = $urandom_range(60, DEPTH - 40);
            l2  = $urandom_range(2, 20);
            wr_mem(s + len, {4'hE, 4'($urandom)});
            wr_mem(t + l2, {4'hE, 4'($urandom)});
            run_prog(s, 0, t, 1'($urandom));
        end

        wr_mem(90, 8'hE0);
        push_walk(60);
        start_pc = 16'd60;
        start = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset", 64'({out_valid, out_pc, out_dec, halted, err}), 64'(0));
        sb_q.delete();
        for (int i = 0; i < 16; i++) lbl_m[i] = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        wr_mem(100, 8'h27); wr_mem(101, 8'h5B); wr_mem(102, 8'hE0);
        run_prog(100, 1, 0, 1'b0);

`ifdef IFU_BOUNDS_CHECK_EN
        start_pc = 16'(DEPTH);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        check("bounds_err", 64'(err), 64'(1));
        check("bounds_halted", 64'(halted), 64'(1));
        check("bounds_no_valid", 64'(out_valid), 64'(0));
`else
        check("err_tied_low", 64'(err), 64'(0));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
